mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 31 +++
 rtl/mem_responder.sv | 175 +++++++++++++++++
 tb/tb_mem_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if
// Request/response bundle between a CPU-side requester and the memory responder.
//   req_valid / req_ready : request handshake (requester -> responder)
//   req_addr  [15:0]      : byte address
//   req_we                : 1 = write, 0 = read
//   req_wdata [7:0]       : write data
//   rsp_valid / rsp_ready : response handshake (responder -> requester)
//   rsp_rdata [7:0]       : read data, 0x00 for writes and errors
//   rsp_err               : access hit an unmapped address
// Modports: master = requester (CPU / bench), slave = responder.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_we;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
// Single-outstanding byte memory responder with programmable wait states.
// Address map: main RAM at 0x0000..2^RAM_AW-1, 256-byte stack page at
// 0xFF00..0xFFFF, everything else unmapped (flagged with rsp_err).
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous, active-high reset (RAM contents are preserved)
//   bus : mem_responder_if.slave request/response bundle
// Parameters:
//   WAIT_CYCLES : wait states between acceptance and response (0..15)
//   RAM_AW      : main RAM address width (8..15)
module mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int RAM_AW      = 10
) (
    input  logic             clk,
    input  logic             rst,
    mem_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic        accept_s;
    logic        enter_resp_s;
    logic        leave_resp_s;

    logic [15:0] addr_r;
    logic        we_r;
    logic [7:0]  wdata_r;

    logic [15:0] acc_addr_s;
    logic        acc_we_s;
    logic [7:0]  acc_wdata_s;
    logic        main_hit_s;
    logic        stack_hit_s;
    logic [7:0]  rd_data_s;

    logic        rsp_valid_r;
    logic [7:0]  rsp_rdata_r;
    logic        rsp_err_r;

    logic [7:0]  main_mem_r  [0:(2**RAM_AW)-1];
    logic [7:0]  stack_mem_r [0:255];

    // Next-state and wait-counter logic of the IDLE/WAIT/RESP controller.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s    = 1'b1;
                    cnt_nxt_s   = WAIT_LD;
                    state_nxt_s = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                cnt_nxt_s = (cnt_r == 4'd0) ? 4'd0 : 4'(cnt_r - 4'd1);
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Controller state and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign enter_resp_s = (state_nxt_s == RESP) && (state_r != RESP) && !rst;
    assign leave_resp_s = (state_r == RESP) && bus.rsp_ready;

    // With zero wait states the access happens on the accept edge itself,
    // before the latched copy exists, so the live request is used then.
    assign acc_addr_s  = accept_s ? bus.req_addr  : addr_r;
    assign acc_we_s    = accept_s ? bus.req_we    : we_r;
    assign acc_wdata_s = accept_s ? bus.req_wdata : wdata_r;

    assign main_hit_s  = (acc_addr_s >> RAM_AW) == 16'd0;
    assign stack_hit_s = acc_addr_s[15:8] == 8'hFF;

    // Read-data selection between the two RAM regions.
    always_comb begin
        rd_data_s = 8'h00;
        if (main_hit_s) begin
            rd_data_s = main_mem_r[acc_addr_s[RAM_AW-1:0]];
        end else if (stack_hit_s) begin
            rd_data_s = stack_mem_r[acc_addr_s[7:0]];
        end else begin
            rd_data_s = 8'h00;
        end
    end

    // Request capture at acceptance; later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= 16'h0000;
            we_r    <= 1'b0;
            wdata_r <= 8'h00;
        end else if (accept_s) begin
            addr_r  <= bus.req_addr;
            we_r    <= bus.req_we;
            wdata_r <= bus.req_wdata;
        end
    end

    // RAM write commit on the edge entering RESP; RAM is never cleared.
    always_ff @(posedge clk) begin
        if (enter_resp_s && acc_we_s) begin
            if (main_hit_s) begin
                main_mem_r[acc_addr_s[RAM_AW-1:0]] <= acc_wdata_s;
            end else if (stack_hit_s) begin
                stack_mem_r[acc_addr_s[7:0]] <= acc_wdata_s;
            end
        end
    end

    // Registered response; held stable until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 8'h00;
            rsp_err_r   <= 1'b0;
        end else if (enter_resp_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= !(main_hit_s || stack_hit_s);
            rsp_rdata_r <= acc_we_s ? 8'h00 : rd_data_s;
        end else if (leave_resp_s) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 8'h00;
            rsp_err_r   <= 1'b0;
        end
    end

    // Ready is gated by rst so it reads low for the whole reset window,
    // including the cycle in which reset is first applied.
    assign bus.req_ready = (state_r == IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Two responders (WAIT_CYCLES = 2 and 0) driven by directed transactions.
// A transaction-level model predicts ready/valid/data every cycle; directed
// calls carry hand-computed latency and data values.
module tb_mem_responder;

    localparam int WC0 = 2;
    localparam int WC1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;

    mem_responder_if if0();
    mem_responder_if if1();

    mem_responder #(.WAIT_CYCLES(WC0), .RAM_AW(10)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
    mem_responder #(.WAIT_CYCLES(WC1), .RAM_AW(10)) dut1 (.clk(clk), .rst(rst1), .bus(if1));

    int checks   = 0;
    int failures = 0;

    // Model state per instance.
    bit         m_pend  [2];
    bit         m_val   [2];
    int         m_left  [2];
    bit         m_we    [2];
    logic [15:0] m_addr [2];
    logic [7:0] m_wd    [2];
    logic [7:0] m_rd    [2];
    bit         m_err   [2];
    bit         m_rdk   [2];
    logic [7:0] m_mem   [2][65536];
    bit         m_known [2][65536];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic int wc(input int i);
        return (i == 0) ? WC0 : WC1;
    endfunction

    function automatic bit mapped(input logic [15:0] a);
        return (a < 16'd1024) || (a >= 16'hFF00);
    endfunction

    function automatic logic get_rst(input int i);   return (i == 0) ? rst0 : rst1; endfunction
    function automatic logic get_v(input int i);     return (i == 0) ? if0.req_valid : if1.req_valid; endfunction
    function automatic logic get_we(input int i);    return (i == 0) ? if0.req_we : if1.req_we; endfunction
    function automatic logic [15:0] get_a(input int i); return (i == 0) ? if0.req_addr : if1.req_addr; endfunction
    function automatic logic [7:0] get_d(input int i);  return (i == 0) ? if0.req_wdata : if1.req_wdata; endfunction
    function automatic logic get_rr(input int i);    return (i == 0) ? if0.rsp_ready : if1.rsp_ready; endfunction
    function automatic logic get_ready(input int i); return (i == 0) ? if0.req_ready : if1.req_ready; endfunction
    function automatic logic get_rv(input int i);    return (i == 0) ? if0.rsp_valid : if1.rsp_valid; endfunction
    function automatic logic [7:0] get_rd(input int i); return (i == 0) ? if0.rsp_rdata : if1.rsp_rdata; endfunction
    function automatic logic get_err(input int i);   return (i == 0) ? if0.rsp_err : if1.rsp_err; endfunction

    task automatic drive(input int i, input logic v, input logic we, input logic [15:0] a, input logic [7:0] d);
        if (i == 0) begin
            if0.req_valid = v; if0.req_we = we; if0.req_addr = a; if0.req_wdata = d;
        end else begin
            if1.req_valid = v; if1.req_we = we; if1.req_addr = a; if1.req_wdata = d;
        end
    endtask

    task automatic set_rr(input int i, input logic v);
        if (i == 0) if0.rsp_ready = v;
        else        if1.rsp_ready = v;
    endtask

    // The transaction completes: memory effect and response contents.
    task automatic complete(input int i);
        m_pend[i] = 1'b0;
        m_val[i]  = 1'b1;
        m_err[i]  = !mapped(m_addr[i]);
        if (m_we[i]) begin
            m_rd[i]  = 8'h00;
            m_rdk[i] = 1'b1;
            if (mapped(m_addr[i])) begin
                m_mem[i][m_addr[i]]   = m_wd[i];
                m_known[i][m_addr[i]] = 1'b1;
            end
        end else if (!mapped(m_addr[i])) begin
            m_rd[i]  = 8'h00;
            m_rdk[i] = 1'b1;
        end else begin
            m_rd[i]  = m_mem[i][m_addr[i]];
            m_rdk[i] = m_known[i][m_addr[i]];
        end
    endtask

    // One clock of the model followed by comparison of all outputs.
    task automatic model_step(input int i);
        logic r;
        r = get_rst(i);
        if (r) begin
            m_pend[i] = 1'b0;
            m_val[i]  = 1'b0;
        end else if (m_val[i]) begin
            if (get_rr(i)) m_val[i] = 1'b0;
        end else if (m_pend[i]) begin
            m_left[i]--;
            if (m_left[i] == 0) complete(i);
        end else if (get_v(i)) begin
            m_we[i]   = get_we(i);
            m_addr[i] = get_a(i);
            m_wd[i]   = get_d(i);
            if (wc(i) == 0) begin
                complete(i);
            end else begin
                m_pend[i] = 1'b1;
                m_left[i] = wc(i);
            end
        end
        check($sformatf("dut%0d_req_ready", i), get_ready(i), !r && !m_pend[i] && !m_val[i]);
        check($sformatf("dut%0d_rsp_valid", i), get_rv(i), m_val[i]);
        if (r) begin
            check($sformatf("dut%0d_rst_rdata", i), get_rd(i), 8'h00);
            check($sformatf("dut%0d_rst_err", i), get_err(i), 1'b0);
        end else if (m_val[i]) begin
            check($sformatf("dut%0d_rsp_err", i), get_err(i), m_err[i]);
            if (m_rdk[i]) check($sformatf("dut%0d_rsp_rdata", i), get_rd(i), m_rd[i]);
        end
    endtask

    // Compare process: evaluated just after every rising edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // One request with hand-computed latency/data, optional backpressure.
    task automatic txn(input int i, input logic we, input logic [15:0] a, input logic [7:0] d,
                       input int bp, input int exp_lat, input logic [7:0] exp_rd,
                       input logic exp_err, input string tag);
        int lat;
        int n;
        bit got;
        @(negedge clk);
        drive(i, 1'b1, we, a, d);
        set_rr(i, 1'b0);
        @(negedge clk);
        drive(i, 1'b0, ~we, ~a, ~d);
        got = 1'b0;
        lat = 0;
        n   = 0;
        while (!got && n < 40) begin
            if (get_rv(i)) begin
                got = 1'b1;
                lat = n + 1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        check({tag, "_rsp_seen"}, got, 1'b1);
        if (got) begin
            check({tag, "_latency"}, lat, exp_lat);
            check({tag, "_rdata"}, get_rd(i), exp_rd);
            check({tag, "_err"}, get_err(i), exp_err);
            for (int k = 0; k < bp; k++) begin
                @(negedge clk);
                check({tag, "_bp_valid"}, get_rv(i), 1'b1);
                check({tag, "_bp_rdata"}, get_rd(i), exp_rd);
                check({tag, "_bp_ready"}, get_ready(i), 1'b0);
            end
            set_rr(i, 1'b1);
            @(negedge clk);
            set_rr(i, 1'b0);
            check({tag, "_idle_ready"}, get_ready(i), 1'b1);
            check({tag, "_idle_valid"}, get_rv(i), 1'b0);
        end
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0; m_val[i] = 1'b0; m_left[i] = 0;
        end
        rst0 = 1'b1;
        rst1 = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        set_rr(0, 1'b0);
        set_rr(1, 1'b0);
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        check("dut0_ready_after_rst", get_ready(0), 1'b1);
        check("dut1_ready_after_rst", get_ready(1), 1'b1);

        // Write then read main RAM, three-cycle response latency.
        txn(0, 1'b1, 16'h0010, 8'h5A, 0, 3, 8'h00, 1'b0, "w_0010");
        txn(0, 1'b0, 16'h0010, 8'h00, 0, 3, 8'h5A, 1'b0, "r_0010");

        // Stack page is separate from main RAM at the same low byte.
        txn(0, 1'b1, 16'h007F, 8'h3C, 0, 3, 8'h00, 1'b0, "w_007f");
        txn(0, 1'b1, 16'hFF7F, 8'hC3, 0, 3, 8'h00, 1'b0, "w_ff7f");
        txn(0, 1'b0, 16'hFF7F, 8'h00, 0, 3, 8'hC3, 1'b0, "r_ff7f");
        txn(0, 1'b0, 16'h007F, 8'h00, 0, 3, 8'h3C, 1'b0, "r_007f");

        // Unmapped accesses flag an error and touch nothing.
        txn(0, 1'b1, 16'h0000, 8'h99, 0, 3, 8'h00, 1'b0, "w_0000");
        txn(0, 1'b0, 16'h8000, 8'h00, 0, 3, 8'h00, 1'b1, "r_8000");
        txn(0, 1'b1, 16'h8000, 8'h77, 0, 3, 8'h00, 1'b1, "w_8000");
        txn(0, 1'b0, 16'h0000, 8'h00, 0, 3, 8'h99, 1'b0, "r_0000");

        // Backpressure for five cycles.
        txn(0, 1'b0, 16'h0010, 8'h00, 5, 3, 8'h5A, 1'b0, "bp_0010");

        // Reset while waiting aborts the write.
        txn(0, 1'b1, 16'h0020, 8'h22, 0, 3, 8'h00, 1'b0, "w_0020");
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 16'h0020, 8'h11);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        rst0 = 1'b1;
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_rsp", get_rv(0), 1'b0);
        end
        txn(0, 1'b0, 16'h0020, 8'h00, 0, 3, 8'h22, 1'b0, "r_0020_after_abort");

        // Zero wait states: one-cycle latency, back-to-back every two cycles.
        txn(1, 1'b1, 16'h0005, 8'hA5, 0, 1, 8'h00, 1'b0, "z_w_0005");
        txn(1, 1'b0, 16'h0005, 8'h00, 0, 1, 8'hA5, 1'b0, "z_r_0005");
        txn(1, 1'b1, 16'hFF00, 8'h5C, 0, 1, 8'h00, 1'b0, "z_w_ff00");
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 16'h0005, 8'h00);
        set_rr(1, 1'b1);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (get_rv(1)) cnt++;
        end
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        set_rr(1, 1'b0);
        check("z_b2b_responses_in_6", cnt, 3);
        txn(1, 1'b0, 16'hFF00, 8'h00, 0, 1, 8'h5C, 1'b0, "z_r_ff00");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
